matmul_ctrl: RTL and testbench
==============================

MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning operand element width (from matmul_pkg).
REQ-002 SHALL have parameter BUS_WIDTH, default 32, meaning bus width; MAX_DIM = BUS_WIDTH/DATA_WIDTH = 4 (from matmul_pkg).
REQ-003 SHALL have parameter SP_NTARGETS, default 4, meaning number of scratchpad result slots (from matmul_pkg).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start_i, input, 1, start request, sampled only in IDLE.
REQ-007 SHALL have ports dim_n_i, dim_k_i, dim_m_i, input, 2 each ($clog2(MAX_DIM)), encoding N, K, M minus 1 (range 1..4).
REQ-008 SHALL have port sp_target_i, input, $clog2(SP_NTARGETS), scratchpad slot for result.
REQ-009 SHALL have port sp_wr_ready_i, input, 1, scratchpad accepts current row write.
REQ-010 SHALL have port pe_clear_o, output, 1, clear all PE accumulators.
REQ-011 SHALL have port pe_en_o, output, 1, PE array advance/accumulate enable.
REQ-012 SHALL have port step_o, output, STEP_W = $clog2(3*MAX_DIM) = 4, compute step counter t.
REQ-013 SHALL have ports a_lane_en_o and b_lane_en_o, output, MAX_DIM each, per-row A and per-column B operand-injection enables.
REQ-014 SHALL have ports sp_wr_en_o (1), sp_wr_row_o (2), sp_wr_target_o ($clog2(SP_NTARGETS)), output, result-row write request, row index, slot.
REQ-015 SHALL have ports busy_o and done_o, output, 1 each, operation in progress; one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, CLEAR, COMPUTE, WRITE, DONE.
REQ-017 SHALL, in IDLE with start_i=1 at an edge, latch N, K, M and sp_target_i, and enter CLEAR; config inputs are ignored outside that edge.
REQ-018 SHALL assert pe_clear_o and busy_o for exactly one cycle in CLEAR, then enter COMPUTE with t=0.
REQ-019 SHALL stay in COMPUTE for exactly T = N+K+M-2 cycles with pe_en_o=1 and step_o=t, t=0..T-1, then enter WRITE.
REQ-020 SHALL drive a_lane_en_o[i] = (i<N) and (t>=i) and (t-i<K), and b_lane_en_o[j] = (j<M) and (t>=j) and (t-j<K), in COMPUTE; all zero otherwise.
REQ-021 SHALL, in WRITE, hold sp_wr_en_o=1, sp_wr_row_o=r, sp_wr_target_o=latched slot, r starting at 0, advancing only on sp_wr_en_o and sp_wr_ready_i both high.
REQ-022 SHALL enter DONE when row N-1 is accepted; outputs shall be held stable while sp_wr_ready_i=0, with no timeout.
REQ-023 SHALL assert done_o for exactly one cycle in DONE, with busy_o=0, then return to IDLE.
REQ-024 SHALL hold busy_o=1 in CLEAR, COMPUTE and WRITE only.
REQ-025 SHALL ignore start_i in every state except IDLE, with no queuing.
REQ-026 SHALL keep pe_en_o, pe_clear_o and sp_wr_en_o mutually exclusive.
REQ-027 SHALL keep step_o and sp_wr_row_o at 0 outside COMPUTE and WRITE respectively; counters never wrap (T<=10, r<=3).

Reset
REQ-028 SHALL, on rst_ni=0 at any time including mid-operation, force IDLE and drive all outputs and counters to 0 asynchronously; latched config cleared to 0.
REQ-029 SHALL, after reset release, take no action until a new start_i in IDLE.

Structure
REQ-030 SHALL source DATA_WIDTH, BUS_WIDTH, SP_NTARGETS and MAX_DIM from matmul_pkg; a state enum typedef and STEP_W constant shall be added to matmul_pkg.
REQ-031 SHALL be a single module; the lane-enable mask logic may be a sub-module named matmul_skew_mask.

Verification
REQ-032 SHALL test N=K=M=4, ready always 1, start at edge 0 -> CLEAR cycle 1, COMPUTE cycles 2-11, WRITE rows 0-3 cycles 12-15, done_o=1 at cycle 16 only.
REQ-033 SHALL test N=K=M=1 -> T=1, single write row 0 at cycle 3, done_o at cycle 4.
REQ-034 SHALL test N=2, K=3, M=4 at t=2 -> a_lane_en_o=4'b0011, b_lane_en_o=4'b0111, T=7.
REQ-035 SHALL test sp_wr_ready_i=0 for 3 cycles on row 1 -> sp_wr_row_o held at 1, done_o delayed exactly 3 cycles.
REQ-036 SHALL test start_i pulsed during COMPUTE and DONE -> ignored, no second operation, config unchanged.
REQ-037 SHALL test rst_ni low at t=5 -> all outputs 0 immediately, IDLE; a following start runs a full correct sequence.

Source files
------------

// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matmul_pkg
// Description : Shared sizing constants and state encoding for the systolic
//               matrix-multiply controller.
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    // Operand element width and operand bus width
    localparam int DATA_WIDTH  = 8;
    localparam int BUS_WIDTH   = 32;

    // Number of scratchpad result slots
    localparam int SP_NTARGETS = 4;

    // Largest supported matrix dimension (elements per bus beat)
    localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH;

    // Compute-step counter width; covers the longest wavefront N+K+M-2
    localparam int STEP_W      = $clog2(3 * MAX_DIM);

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage : matmul_pkg
`default_nettype wire

// File: rtl/matmul_skew_mask.sv
`default_nettype none
// ============================================================================
// Module      : matmul_skew_mask
// Description : Diagonal (skewed) operand-injection masks for the PE array.
//               Row i of A and column j of B are fed while the wavefront step
//               t covers their K elements, i.e. i <= t < i+K.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_skew_mask #(
    parameter int MAX_DIM = 4,
    parameter int DIM_W   = 2,
    parameter int STEP_W  = 4
) (
    input  logic               i_en,
    input  logic [STEP_W-1:0]  i_step,
    input  logic [DIM_W-1:0]   i_n,
    input  logic [DIM_W-1:0]   i_k,
    input  logic [DIM_W-1:0]   i_m,
    output logic [MAX_DIM-1:0] o_a_en,
    output logic [MAX_DIM-1:0] o_b_en
);

    // Dimensions arrive minus one; widen them to the step domain once
    logic [STEP_W-1:0] w_n;
    logic [STEP_W-1:0] w_k;
    logic [STEP_W-1:0] w_m;

    assign w_n = STEP_W'(i_n);
    assign w_k = STEP_W'(i_k);
    assign w_m = STEP_W'(i_m);

    // One lane per row of A / column of B; index compared against step t
    for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_lane
        localparam logic [STEP_W-1:0] c_IDX = STEP_W'(gi);
        logic [STEP_W-1:0] w_off;

        // Offset into the K-long stream; only meaningful when t >= index
        assign w_off       = i_step - c_IDX;
        assign o_a_en[gi]  = i_en && (c_IDX <= w_n) && (i_step >= c_IDX) && (w_off <= w_k);
        assign o_b_en[gi]  = i_en && (c_IDX <= w_m) && (i_step >= c_IDX) && (w_off <= w_k);
    end

endmodule : matmul_skew_mask
`default_nettype wire

// File: rtl/matmul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : matmul_ctrl
// Description : Sequencer for an output-stationary systolic matmul array.
//               Clears the PE accumulators, runs the skewed compute wavefront
//               for N+K+M-2 steps, then writes the N result rows to the
//               selected scratchpad slot under ready/enable handshaking.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_ctrl #(
    parameter int DATA_WIDTH  = matmul_pkg::DATA_WIDTH,
    parameter int BUS_WIDTH   = matmul_pkg::BUS_WIDTH,
    parameter int SP_NTARGETS = matmul_pkg::SP_NTARGETS
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         start_i,
    input  logic [$clog2(BUS_WIDTH/DATA_WIDTH)-1:0]      dim_n_i,
    input  logic [$clog2(BUS_WIDTH/DATA_WIDTH)-1:0]      dim_k_i,
    input  logic [$clog2(BUS_WIDTH/DATA_WIDTH)-1:0]      dim_m_i,
    input  logic [$clog2(SP_NTARGETS)-1:0]               sp_target_i,
    input  logic                                         sp_wr_ready_i,
    output logic                                         pe_clear_o,
    output logic                                         pe_en_o,
    output logic [$clog2(3*(BUS_WIDTH/DATA_WIDTH))-1:0]  step_o,
    output logic [BUS_WIDTH/DATA_WIDTH-1:0]              a_lane_en_o,
    output logic [BUS_WIDTH/DATA_WIDTH-1:0]              b_lane_en_o,
    output logic                                         sp_wr_en_o,
    output logic [$clog2(BUS_WIDTH/DATA_WIDTH)-1:0]      sp_wr_row_o,
    output logic [$clog2(SP_NTARGETS)-1:0]               sp_wr_target_o,
    output logic                                         busy_o,
    output logic                                         done_o
);

    import matmul_pkg::*;

    localparam int c_MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int c_DIM_W   = $clog2(c_MAX_DIM);
    localparam int c_TGT_W   = $clog2(SP_NTARGETS);
    localparam int c_STEP_W  = $clog2(3 * c_MAX_DIM);

    localparam logic [2:0] c_S_IDLE    = ST_IDLE;
    localparam logic [2:0] c_S_CLEAR   = ST_CLEAR;
    localparam logic [2:0] c_S_COMPUTE = ST_COMPUTE;
    localparam logic [2:0] c_S_WRITE   = ST_WRITE;
    localparam logic [2:0] c_S_DONE    = ST_DONE;

    logic [2:0]          r_state;
    logic [c_STEP_W-1:0] r_step;
    logic [c_DIM_W-1:0]  r_row;
    logic [c_DIM_W-1:0]  r_n;
    logic [c_DIM_W-1:0]  r_k;
    logic [c_DIM_W-1:0]  r_m;
    logic [c_TGT_W-1:0]  r_tgt;

    logic                w_idle;
    logic                w_clear;
    logic                w_compute;
    logic                w_write;
    logic                w_done;
    logic [c_STEP_W-1:0] w_last_step;

    assign w_idle    = (r_state == c_S_IDLE);
    assign w_clear   = (r_state == c_S_CLEAR);
    assign w_compute = (r_state == c_S_COMPUTE);
    assign w_write   = (r_state == c_S_WRITE);
    assign w_done    = (r_state == c_S_DONE);

    // Final step index T-1 = (N+K+M-2)-1, which equals the sum of the encoded dims
    assign w_last_step = c_STEP_W'(r_n) + c_STEP_W'(r_k) + c_STEP_W'(r_m);

    // Capture the operation config only on an accepted start
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_n   <= '0;
            r_k   <= '0;
            r_m   <= '0;
            r_tgt <= '0;
        end else if (w_idle && start_i) begin
            r_n   <= dim_n_i;
            r_k   <= dim_k_i;
            r_m   <= dim_m_i;
            r_tgt <= sp_target_i;
        end
    end

    // Sequencer state with its step and row counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_S_IDLE;
            r_step  <= '0;
            r_row   <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start_i) begin
                        r_state <= c_S_CLEAR;
                    end
                end
                c_S_CLEAR: begin
                    r_state <= c_S_COMPUTE;
                    r_step  <= '0;
                end
                c_S_COMPUTE: begin
                    if (r_step == w_last_step) begin
                        r_state <= c_S_WRITE;
                        r_step  <= '0;
                        r_row   <= '0;
                    end else begin
                        r_step  <= r_step + 1'b1;
                    end
                end
                c_S_WRITE: begin
                    if (sp_wr_ready_i) begin
                        if (r_row == r_n) begin
                            r_state <= c_S_DONE;
                            r_row   <= '0;
                        end else begin
                            r_row   <= r_row + 1'b1;
                        end
                    end
                end
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_step  <= '0;
                    r_row   <= '0;
                end
            endcase
        end
    end

    // Lane masks follow the step counter during the compute wavefront
    matmul_skew_mask #(
        .MAX_DIM (c_MAX_DIM),
        .DIM_W   (c_DIM_W),
        .STEP_W  (c_STEP_W)
    ) u_skew_mask (
        .i_en    (w_compute),
        .i_step  (r_step),
        .i_n     (r_n),
        .i_k     (r_k),
        .i_m     (r_m),
        .o_a_en  (a_lane_en_o),
        .o_b_en  (b_lane_en_o)
    );

    // Moore outputs decoded from state; counters are masked outside their phase
    assign pe_clear_o     = w_clear;
    assign pe_en_o        = w_compute;
    assign step_o         = w_compute ? r_step : '0;
    assign sp_wr_en_o     = w_write;
    assign sp_wr_row_o    = w_write ? r_row : '0;
    assign sp_wr_target_o = w_write ? r_tgt : '0;
    assign busy_o         = w_clear | w_compute | w_write;
    assign done_o         = w_done;

endmodule : matmul_ctrl
`default_nettype wire

// File: tb/tb_matmul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_ctrl
// Description : Scoreboard bench for matmul_ctrl. Each operation is expanded
//               by a cycle-level reference model into the expected output
//               trace, queued, and compared by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_ctrl;

    typedef struct packed {
        logic       clr;
        logic       en;
        logic [3:0] step;
        logic [3:0] a;
        logic [3:0] b;
        logic       wr;
        logic [1:0] row;
        logic [1:0] tgt;
        logic       busy;
        logic       done;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] dim_n;
    logic [1:0] dim_k;
    logic [1:0] dim_m;
    logic [1:0] target;
    logic       wr_ready;
    logic       pe_clear;
    logic       pe_en;
    logic [3:0] step;
    logic [3:0] a_en;
    logic [3:0] b_en;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [1:0] wr_target;
    logic       busy;
    logic       done;

    obs_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    matmul_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .dim_n_i        (dim_n),
        .dim_k_i        (dim_k),
        .dim_m_i        (dim_m),
        .sp_target_i    (target),
        .sp_wr_ready_i  (wr_ready),
        .pe_clear_o     (pe_clear),
        .pe_en_o        (pe_en),
        .step_o         (step),
        .a_lane_en_o    (a_en),
        .b_lane_en_o    (b_en),
        .sp_wr_en_o     (wr_en),
        .sp_wr_row_o    (wr_row),
        .sp_wr_target_o (wr_target),
        .busy_o         (busy),
        .done_o         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t sample();
        obs_t s;
        s.clr  = pe_clear;
        s.en   = pe_en;
        s.step = step;
        s.a    = a_en;
        s.b    = b_en;
        s.wr   = wr_en;
        s.row  = wr_row;
        s.tgt  = wr_target;
        s.busy = busy;
        s.done = done;
        return s;
    endfunction

    task automatic report(input string name, input obs_t got, input obs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got clr=%b en=%b step=%0d a=%b b=%b wr=%b row=%0d tgt=%0d busy=%b done=%b, expected clr=%b en=%b step=%0d a=%b b=%b wr=%b row=%0d tgt=%0d busy=%b done=%b",
                     name, $time,
                     got.clr, got.en, got.step, got.a, got.b, got.wr, got.row, got.tgt, got.busy, got.done,
                     exp.clr, exp.en, exp.step, exp.a, exp.b, exp.wr, exp.row, exp.tgt, exp.busy, exp.done);
        end
    endtask

    // Monitor: one expected record per cycle while the scoreboard holds any
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                obs_t e;
                e = sb.pop_front();
                report("cycle_outputs", sample(), e);
            end
        end
    end

    // Reference trace: cycle 0 is the cycle start is presented, cycle 1 clear,
    // then T compute steps, then row writes gated by ready, then done, then idle.
    task automatic build_trace(input int n, input int k, input int m, input int tgt,
                               input int rdy[64], output obs_t tr[$], output int done_c);
        obs_t e;
        int   t_len;
        int   c;
        int   r;
        tr    = {};
        t_len = n + k + m - 2;
        e = '0;
        tr.push_back(e);
        e = '0; e.clr = 1'b1; e.busy = 1'b1;
        tr.push_back(e);
        for (int t = 0; t < t_len; t++) begin
            e = '0; e.en = 1'b1; e.busy = 1'b1; e.step = 4'(t);
            for (int i = 0; i < 4; i++) begin
                e.a[i] = (i < n) && (t >= i) && (t - i < k);
                e.b[i] = (i < m) && (t >= i) && (t - i < k);
            end
            tr.push_back(e);
        end
        c = t_len + 2;
        r = 0;
        while (r < n) begin
            e = '0; e.wr = 1'b1; e.busy = 1'b1; e.row = 2'(r); e.tgt = 2'(tgt);
            tr.push_back(e);
            if (rdy[c] != 0) r++;
            c++;
        end
        done_c = c;
        e = '0; e.done = 1'b1;
        tr.push_back(e);
        e = '0;
        tr.push_back(e);
        tr.push_back(e);
    endtask

    task automatic make_ready(input int n, input int k, input int m, input int mode, output int rdy[64]);
        int t_len;
        t_len = n + k + m - 2;
        for (int c = 0; c < 64; c++) begin
            case (mode)
                1:       rdy[c] = ($urandom_range(0, 3) != 0) ? 1 : 0;
                2:       rdy[c] = (c >= t_len + 3 && c <= t_len + 5) ? 0 : 1;
                default: rdy[c] = 1;
            endcase
            if (c >= 40) rdy[c] = 1;
        end
    endtask

    task automatic scramble_cfg();
        dim_n  = 2'($urandom);
        dim_k  = 2'($urandom);
        dim_m  = 2'($urandom);
        target = 2'($urandom);
    endtask

    // One full operation; pulse adds stray starts in COMPUTE and DONE
    task automatic run_op(input int n, input int k, input int m, input int tgt,
                          input int mode, input bit pulse);
        int   rdy[64];
        obs_t tr[$];
        int   done_c;
        make_ready(n, k, m, mode, rdy);
        build_trace(n, k, m, tgt, rdy, tr, done_c);
        @(posedge clk); #1;
        foreach (tr[i]) sb.push_back(tr[i]);
        for (int c = 0; c < tr.size(); c++) begin
            if (c != 0) begin
                @(posedge clk); #1;
            end
            wr_ready = rdy[c][0];
            if (c == 0) begin
                start  = 1'b1;
                dim_n  = 2'(n - 1);
                dim_k  = 2'(k - 1);
                dim_m  = 2'(m - 1);
                target = 2'(tgt);
            end else begin
                start = pulse && (c == 2 || c == done_c);
                scramble_cfg();
            end
        end
        start = 1'b0;
    endtask

    // Reset dropped asynchronously at compute step t=5 of a 4x4x4 operation
    task automatic reset_mid();
        int   rdy[64];
        obs_t tr[$];
        int   done_c;
        obs_t z;
        make_ready(4, 4, 4, 0, rdy);
        build_trace(4, 4, 4, 2, rdy, tr, done_c);
        z = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) sb.push_back(tr[i]);
        for (int i = 0; i < 3; i++) sb.push_back(z);
        start    = 1'b1;
        dim_n    = 2'd3;
        dim_k    = 2'd3;
        dim_m    = 2'd3;
        target   = 2'd2;
        wr_ready = 1'b1;
        for (int c = 1; c < 7; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            scramble_cfg();
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        report("async_reset_outputs", sample(), z);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        obs_t z;
        z        = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dim_n    = '0;
        dim_k    = '0;
        dim_m    = '0;
        target   = '0;
        wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) sb.push_back(z);
        #27;
        rst_n = 1'b1;

        run_op(4, 4, 4, 1, 0, 1'b0);
        run_op(1, 1, 1, 3, 0, 1'b0);
        run_op(2, 3, 4, 2, 0, 1'b0);
        run_op(4, 4, 4, 0, 2, 1'b0);
        run_op(3, 2, 4, 3, 1, 1'b1);
        reset_mid();
        run_op(4, 4, 4, 2, 0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            run_op(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                   int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                   1, 1'($urandom));
        end

        repeat (3) @(posedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d records left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_matmul_ctrl
`default_nettype wire
